// File: rtl/deco_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, its binary index, and a
// combinational "is index querySel the current owner" query.
module deco_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = (N > 1) ? $clog2(N) : 1,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     request,
  input  logic             release_req,  // "release" is a reserved word
  input  logic [SEL_W-1:0] querySel,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grantIdx,
  output logic             grantValid,
  output logic             queryHit,
  output logic             timeoutPulse
);

  localparam int               HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N - 1);
  localparam logic [SEL_W:0]   N_EXT  = (SEL_W + 1)'(N);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t            state;
  logic [SEL_W-1:0]  pointer;
  logic [HOLD_W-1:0] hold;

  logic [N-1:0]      others;
  logic              drop;
  logic              timeout;
  logic              end_grant;
  logic [SEL_W-1:0]  next_ptr;
  logic [SEL_W:0]    idle_pick;
  logic [SEL_W:0]    move_pick;

  // Returns {found, index} of the first set bit of req scanning upward from
  // start and wrapping N-1 -> 0.
  function automatic logic [SEL_W:0] pick(input logic [N-1:0]     req,
                                          input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cur;
    found = 1'b0;
    idx   = '0;
    cur   = start;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cur]) begin
        found = 1'b1;
        idx   = cur;
      end
      cur = (cur == LAST) ? '0 : cur + SEL_W'(1);
    end
    return {found, idx};
  endfunction

  // NOTE: every signal gets a value on every path of always_comb, otherwise a latch is inferred.
  always_comb begin
    others    = request & ~grant;
    drop      = ~|(request & grant);
    timeout   = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD)) && (|others);
    end_grant = release_req || drop || timeout;
    next_ptr  = (grantIdx == LAST) ? '0 : grantIdx + SEL_W'(1);
    idle_pick = pick(request, pointer);
    move_pick = pick(others, next_ptr);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      grantIdx     <= '0;
      pointer      <= '0;
      hold         <= '0;
      timeoutPulse <= 1'b0;
    end else begin
      timeoutPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (en && idle_pick[SEL_W]) begin
            state    <= GRANTED;
            grantIdx <= idle_pick[SEL_W-1:0];
            grant    <= N'(1) << idle_pick[SEL_W-1:0];
            hold     <= HOLD_W'(1);
          end
        end
        GRANTED: begin
          if (end_grant) begin
            pointer      <= next_ptr;
            // Only a pure timeout is reported; release or drop take precedence.
            timeoutPulse <= timeout && !release_req && !drop;
            if (en && move_pick[SEL_W]) begin
              grantIdx <= move_pick[SEL_W-1:0];
              grant    <= N'(1) << move_pick[SEL_W-1:0];
              hold     <= HOLD_W'(1);
            end else begin
              state    <= IDLE;
              grantIdx <= '0;
              grant    <= '0;
              hold     <= '0;
            end
          end else if (MAX_HOLD != 0 && hold != HOLD_W'(MAX_HOLD)) begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grantValid = (state == GRANTED);
  assign queryHit   = grantValid && (querySel == grantIdx) && ({1'b0, querySel} < N_EXT);

endmodule

// File: tb/tb_deco_rr_arbiter.sv
// Scoreboard bench: two arbiter instances (N=8 with hold timeout, N=5 without)
// share one stimulus stream and are checked against an integer reference model.
module tb_deco_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] request;
  logic       rel;
  logic [2:0] querySel;

  logic [7:0] grant_a;
  logic [2:0] idx_a;
  logic       valid_a, hit_a, tp_a;
  logic [4:0] grant_b;
  logic [2:0] idx_b;
  logic       valid_b, hit_b, tp_b;

  deco_rr_arbiter #(.N(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .request(request), .release_req(rel),
    .querySel(querySel), .grant(grant_a), .grantIdx(idx_a), .grantValid(valid_a),
    .queryHit(hit_a), .timeoutPulse(tp_a)
  );

  deco_rr_arbiter #(.N(5), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .request(request[4:0]), .release_req(rel),
    .querySel(querySel), .grant(grant_b), .grantIdx(idx_b), .grantValid(valid_b),
    .queryHit(hit_b), .timeoutPulse(tp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int owner;  // -1 when idle
    int ptr;
    int hold;
    bit tp;
  } mstate_t;

  mstate_t sa, sb;
  mstate_t qa[$], qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int first_from(logic [7:0] req, int start, int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (start + k) % n;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // One clock edge of the arbiter described in terms of "who owns the resource".
  function automatic mstate_t model_step(mstate_t s, int n, int maxh, bit rst_v,
                                         bit en_v, logic [7:0] req_full, bit rel_v);
    mstate_t    r;
    logic [7:0] req, others;
    bit         dropped, timed;
    r    = s;
    r.tp = 1'b0;
    req  = req_full & 8'((1 << n) - 1);
    if (!rst_v) begin
      r.owner = -1; r.ptr = 0; r.hold = 0;
      return r;
    end
    if (s.owner < 0) begin
      if (en_v && req != 0) begin
        r.owner = first_from(req, s.ptr, n);
        r.hold  = 1;
      end
    end else begin
      others           = req;
      others[s.owner]  = 1'b0;
      dropped          = !req[s.owner];
      timed            = maxh > 0 && s.hold == maxh && others != 0;
      if (rel_v || dropped || timed) begin
        r.ptr = (s.owner + 1) % n;
        r.tp  = timed && !rel_v && !dropped;
        if (en_v && others != 0) begin
          r.owner = first_from(others, r.ptr, n);
          r.hold  = 1;
        end else begin
          r.owner = -1;
          r.hold  = 0;
        end
      end else if (maxh > 0 && s.hold < maxh) begin
        r.hold = s.hold + 1;
      end
    end
    return r;
  endfunction

  task automatic compare(string tag, mstate_t e, int n, logic [7:0] g, logic [2:0] gi,
                         logic gv, logic qh, logic tp);
    logic [7:0] eg;
    eg = (e.owner >= 0) ? 8'(1 << e.owner) : 8'h00;
    check({tag, ".grant"}, 32'(g), 32'(eg));
    check({tag, ".grantIdx"}, 32'(gi), (e.owner >= 0) ? 32'(e.owner) : 32'd0);
    check({tag, ".grantValid"}, 32'(gv), 32'(e.owner >= 0));
    check({tag, ".timeoutPulse"}, 32'(tp), 32'(e.tp));
    check({tag, ".queryHit"}, 32'(qh),
          32'(e.owner >= 0 && int'(querySel) == e.owner && int'(querySel) < n));
  endtask

  // Monitor: the DUT presents a fresh registered result every cycle.
  always @(negedge clk) begin
    if (qa.size() > 0 && qb.size() > 0) begin
      mstate_t ea, eb;
      ea = qa.pop_front();
      eb = qb.pop_front();
      compare("a", ea, 8, grant_a, idx_a, valid_a, hit_a, tp_a);
      compare("b", eb, 5, {3'b000, grant_b}, idx_b, valid_b, hit_b, tp_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    sa = model_step(sa, 8, 4, rst_n, en, request, rel);
    sb = model_step(sb, 5, 0, rst_n, en, request, rel);
    qa.push_back(sa);
    qb.push_back(sb);
    #1;
  endtask

  task automatic drive(bit r, bit e, logic [7:0] rq, bit rl, logic [2:0] qs);
    rst_n    = r;
    en       = e;
    request  = rq;
    rel      = rl;
    querySel = qs;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rq;
    sa = '{owner: -1, ptr: 0, hold: 0, tp: 1'b0};
    sb = sa;
    rst_n = 1'b0; en = 1'b0; request = '0; rel = 1'b0; querySel = '0;

    drive(0, 0, 8'h00, 0, 3'd0);
    drive(0, 0, 8'h00, 0, 3'd0);

    // Single requester, then query hit / miss.
    drive(1, 1, 8'h04, 0, 3'd2);
    drive(1, 1, 8'h04, 0, 3'd2);
    drive(1, 1, 8'h04, 0, 3'd3);

    // All requesting, release every other cycle: full rotation with wrap.
    for (int k = 0; k < 18; k++) drive(1, 1, 8'hFF, (k % 2) == 1, 3'(k));

    // Hold timeout between two requesters, then a sole requester.
    for (int k = 0; k < 12; k++) drive(1, 1, 8'h03, 0, 3'd0);
    for (int k = 0; k < 10; k++) drive(1, 1, 8'h01, 0, 3'd0);

    // Owner 5 drops while 6 waits, then everyone drops.
    drive(1, 1, 8'h00, 0, 3'd5);
    drive(1, 1, 8'h20, 0, 3'd5);
    drive(1, 1, 8'h60, 0, 3'd5);
    drive(1, 1, 8'h40, 0, 3'd6);
    drive(1, 1, 8'h40, 0, 3'd6);
    drive(1, 1, 8'h00, 0, 3'd6);
    drive(1, 1, 8'h00, 0, 3'd6);

    // Enable gating: no new grant, but a held grant still ends on release.
    for (int k = 0; k < 3; k++) drive(1, 0, 8'h10, 0, 3'd4);
    drive(1, 1, 8'h10, 0, 3'd4);
    drive(1, 0, 8'h10, 0, 3'd4);
    drive(1, 0, 8'h10, 1, 3'd4);
    for (int k = 0; k < 3; k++) drive(1, 0, 8'h10, 0, 3'd4);
    drive(1, 1, 8'h10, 0, 3'd4);
    drive(1, 1, 8'h10, 0, 3'd4);

    // Reset while granted, then pointer restarts at 0.
    drive(1, 1, 8'h00, 0, 3'd3);
    drive(1, 1, 8'h08, 0, 3'd3);
    drive(1, 1, 8'h08, 0, 3'd3);
    drive(0, 1, 8'h08, 0, 3'd3);
    for (int k = 0; k < 3; k++) drive(1, 1, 8'h18, 0, 3'd3);

    // Randomized traffic with persistent requests so timeouts occur.
    rq = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        rq = 8'($urandom);
        if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
      end
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 4) != 0, rq,
            $urandom_range(0, 5) == 0, 3'($urandom));
    end

    @(negedge clk);
    #1;
    check("drain", 32'(qa.size() + qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
